// File: rtl/aes_key_loader.sv
// aes_key_loader: assembles a 128-bit cipher key from a word stream, issues it to the key expander and tracks completion
module aes_key_loader #(
    parameter int KEY_L    = 128,
    parameter int WORD_W   = 32,
    parameter int MAX_WAIT = 32,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic             s_last,
    output logic             kg_valid_in,
    output logic [KEY_L-1:0] cipher_key,
    input  logic             kg_done,
    output logic             key_ready,
    output logic             busy,
    output logic             err_len,
    output logic             err_timeout,
    output logic [CNT_W-1:0] key_count
);
    localparam int NW   = KEY_L / WORD_W;
    localparam int WC_W = $clog2(NW);
    localparam int WT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT} state_t;

    state_t           state;
    logic [WC_W-1:0]  word_cnt;
    logic [WT_W-1:0]  wait_cnt;
    logic [KEY_L-1:0] shadow;
    logic             beat;
    logic             last_slot;

    assign s_ready   = state == COLLECT;
    assign busy      = state != COLLECT;
    assign beat      = s_valid && s_ready;
    assign last_slot = word_cnt == WC_W'(NW - 1);

    // shadow shifts left so the first word ends up most significant after NW beats
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            word_cnt    <= '0;
            wait_cnt    <= '0;
            shadow      <= '0;
            cipher_key  <= '0;
            kg_valid_in <= 1'b0;
            key_ready   <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            key_count   <= '0;
        end else begin
            kg_valid_in <= 1'b0;
            err_len     <= 1'b0;
            case (state)
                COLLECT: if (beat) begin
                    shadow <= {shadow[KEY_L-WORD_W-1:0], s_data};
                    if (word_cnt == '0) err_timeout <= 1'b0;
                    if (s_last != last_slot) begin
                        err_len  <= 1'b1;
                        word_cnt <= '0;
                    end else if (last_slot) begin
                        state       <= ISSUE;
                        word_cnt    <= '0;
                        cipher_key  <= {shadow[KEY_L-WORD_W-1:0], s_data};
                        kg_valid_in <= 1'b1;
                        key_ready   <= 1'b0;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // completion takes priority over a simultaneous watchdog expiry
                    if (kg_done) begin
                        key_ready <= 1'b1;
                        key_count <= key_count + 1'b1;
                        state     <= COLLECT;
                    end else if (wait_cnt == WT_W'(MAX_WAIT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
